// File: rtl/id_scoreboard.sv
// ID-stage register-dependency scoreboard.
// Keeps one countdown per architectural register holding the cycles left
// until its pending result can be bypassed. The all-ones count means
// "long-latency producer, released only by writeback". Drives the
// combinational stall that holds PC/ID and bubbles EXE.
module id_scoreboard #(
  parameter int  NUM_REGS = 32,
  parameter int  NUM_SRC  = 2,
  parameter int  LAT_W    = 3,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]    src_used,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [AW-1:0]         issue_dst,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_dst,
  input  logic                  flush,
  output logic                  stall,
  output logic [NUM_SRC-1:0]    src_ready,
  output logic [NUM_REGS-1:0]   pend_vec
);

  localparam logic [LAT_W-1:0] LAT_UNK = '1;

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic                waw_block;
  logic                fire;

  // Per-source readiness; a matching writeback this cycle bypasses into ID.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    src_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = !src_used[i]
                  || (src_addr[i*AW +: AW] == '0)
                  || (cnt_q[src_addr[i*AW +: AW]] == '0)
                  || (wb_valid && (wb_dst == src_addr[i*AW +: AW]));
    end
  end

  // A second writer to a register still owned by a long-latency producer must
  // wait for that writeback, otherwise the older result would land last.
  assign waw_block = issue_wr && (issue_dst != '0)
                  && (cnt_q[issue_dst] == LAT_UNK)
                  && !(wb_valid && (wb_dst == issue_dst));

  assign stall = issue_valid && (!(&src_ready) || waw_block);
  assign fire  = issue_valid && !stall && !flush;

  // Next counter value per register; issue beats flush beats writeback beats decay.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      // NOTE: combinational logic uses blocking assignments; only clocked state uses <=.
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (fire && issue_wr && (issue_dst == AW'(r)) && (issue_lat != '0)) begin
        cnt_d[r] = issue_lat;
      end else if (flush && (cnt_q[r] != LAT_UNK)) begin
        cnt_d[r] = '0;
      end else if (wb_valid && (wb_dst == AW'(r))) begin
        cnt_d[r] = '0;
      end else if ((cnt_q[r] != '0) && (cnt_q[r] != LAT_UNK)) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
      pend_d[r] = (cnt_d[r] != '0);
    end
  end

  // Counter and pending-vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is reset on purpose: a stale count after reset would stall or wrongly bypass.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      pend_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      pend_q <= pend_d;
    end
  end

  assign pend_vec = pend_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios followed by a
// random phase, all compared against a cycle-level reference model.
module tb_id_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;
  localparam int LAT_W    = 3;
  localparam int AW       = 5;
  localparam int LAT_UNK  = 7;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic [NUM_SRC-1:0]    src_used;
  logic                  issue_valid;
  logic                  issue_wr;
  logic [AW-1:0]         issue_dst;
  logic [LAT_W-1:0]      issue_lat;
  logic                  wb_valid;
  logic [AW-1:0]         wb_dst;
  logic                  flush;
  logic                  stall;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_REGS-1:0]   pend_vec;

  id_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst(rst), .src_addr(src_addr), .src_used(src_used),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dst(issue_dst),
    .issue_lat(issue_lat), .wb_valid(wb_valid), .wb_dst(wb_dst), .flush(flush),
    .stall(stall), .src_ready(src_ready), .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

  // Reference model: remaining cycles per register until its value is usable.
  int m_cnt [NUM_REGS];
  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int src_of(input int i);
    return int'(src_addr[i*AW +: AW]);
  endfunction

  // Operand i can be read now if unused, r0, idle, or written back this cycle.
  function automatic bit m_ready(input int i);
    int a = src_of(i);
    return !src_used[i] || a == 0 || m_cnt[a] == 0 || (wb_valid && int'(wb_dst) == a);
  endfunction

  function automatic bit m_stall();
    bit any_wait = 0;
    bit waw;
    for (int i = 0; i < NUM_SRC; i++) if (!m_ready(i)) any_wait = 1;
    waw = issue_wr && issue_dst != 0 && m_cnt[issue_dst] == LAT_UNK
          && !(wb_valid && wb_dst == issue_dst);
    return issue_valid && (any_wait || waw);
  endfunction

  // Check the current outputs against the model, then step model and DUT one edge.
  task automatic cyc();
    logic [NUM_SRC-1:0]  er;
    logic [NUM_REGS-1:0] ep;
    int nxt [NUM_REGS];
    bit fire;
    #1;
    for (int i = 0; i < NUM_SRC; i++) er[i] = m_ready(i);
    for (int r = 0; r < NUM_REGS; r++) ep[r] = (m_cnt[r] != 0);
    check("stall", 64'(stall), 64'(m_stall()));
    check("src_ready", 64'(src_ready), 64'(er));
    check("pend_vec", 64'(pend_vec), 64'(ep));
    fire = issue_valid && !m_stall() && !flush;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rst) nxt[r] = 0;
      else if (r != 0 && fire && issue_wr && int'(issue_dst) == r && issue_lat != 0)
        nxt[r] = int'(issue_lat);
      else if (flush && m_cnt[r] != LAT_UNK) nxt[r] = 0;
      else if (wb_valid && int'(wb_dst) == r) nxt[r] = 0;
      else if (m_cnt[r] > 0 && m_cnt[r] < LAT_UNK) nxt[r] = m_cnt[r] - 1;
      else nxt[r] = m_cnt[r];
    end
    @(posedge clk);
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = nxt[r];
    #1;
  endtask

  task automatic idle();
    rst = 0; src_addr = '0; src_used = '0; issue_valid = 0; issue_wr = 0;
    issue_dst = '0; issue_lat = '0; wb_valid = 0; wb_dst = '0; flush = 0;
  endtask

  task automatic iss(input int dst, input int lat);
    idle();
    issue_valid = 1; issue_wr = 1; issue_dst = AW'(dst); issue_lat = LAT_W'(lat);
  endtask

  task automatic rd(input int a0, input int a1, input logic [1:0] used);
    idle();
    issue_valid = 1; src_addr = {AW'(a1), AW'(a0)}; src_used = used;
  endtask

  initial begin
    for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
    idle();
    rst = 1;
    cyc();
    cyc();
    idle();
    #1;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_ready", 64'(src_ready), 64'h3);
    check("reset_pend", 64'(pend_vec), 64'd0);
    cyc();

    // Classic load-use: one bubble.
    iss(5, 1); cyc();
    rd(5, 0, 2'b01); #1;
    check("lu_stall", 64'(stall), 64'd1);
    check("lu_pend", 64'(pend_vec), 64'(32'd1 << 5));
    cyc();
    #1;
    check("lu_fire", 64'(stall), 64'd0);
    cyc();
    idle(); #1;
    check("lu_pend_clr", 64'(pend_vec), 64'd0);
    cyc();

    // Latency 3: exactly three stall cycles; unrelated read never stalls.
    iss(7, 3); cyc();
    rd(7, 0, 2'b01);
    for (int k = 0; k < 3; k++) begin
      #1; check("l3_stall", 64'(stall), 64'd1); cyc();
    end
    #1; check("l3_release", 64'(stall), 64'd0); cyc();
    iss(7, 3); cyc();
    rd(9, 0, 2'b01);
    for (int k = 0; k < 4; k++) begin
      #1; check("l3_other", 64'(stall), 64'd0); cyc();
    end

    // Long latency held until writeback, released by same-cycle bypass.
    iss(3, LAT_UNK); cyc();
    rd(3, 0, 2'b01);
    for (int k = 0; k < 20; k++) begin
      #1; check("unk_stall", 64'(stall), 64'd1); cyc();
    end
    wb_valid = 1; wb_dst = 5'd3; #1;
    check("unk_bypass", 64'(stall), 64'd0);
    cyc();
    idle(); #1;
    check("unk_pend_clr", 64'(pend_vec[3]), 64'd0);
    cyc();

    // Flush spares long-latency entries; WAW on r3 waits for its writeback.
    iss(3, LAT_UNK); cyc();
    iss(4, 2); cyc();
    idle(); flush = 1; cyc();
    idle(); #1;
    check("flush_r4", 64'(pend_vec[4]), 64'd0);
    check("flush_r3", 64'(pend_vec[3]), 64'd1);
    cyc();
    iss(3, 1);
    for (int k = 0; k < 8; k++) begin
      #1; check("waw_stall", 64'(stall), 64'd1); cyc();
    end
    wb_valid = 1; wb_dst = 5'd3; #1;
    check("waw_release", 64'(stall), 64'd0);
    cyc();
    idle(); #1;
    check("waw_new_pend", 64'(pend_vec[3]), 64'd1);
    cyc();
    #1; check("waw_new_clr", 64'(pend_vec[3]), 64'd0);
    cyc();

    // r0 is never tracked; unused operands are always ready.
    iss(0, 3); cyc();
    rd(0, 0, 2'b11); #1;
    check("r0_stall", 64'(stall), 64'd0);
    check("r0_pend", 64'(pend_vec), 64'd0);
    cyc();
    iss(10, LAT_UNK); cyc();
    rd(10, 10, 2'b00); #1;
    check("unused_ready", 64'(src_ready), 64'h3);
    cyc();
    rd(0, 10, 2'b10); #1;
    check("src1_busy", 64'(src_ready), 64'h1);
    cyc();

    // Issue beats writeback on the same register; reset clears everything.
    iss(6, 2); wb_valid = 1; wb_dst = 5'd6; cyc();
    idle(); #1;
    check("iss_wins", 64'(pend_vec[6]), 64'd1);
    cyc();
    #1; check("iss_wins_l1", 64'(pend_vec[6]), 64'd1);
    iss(12, 5); cyc();
    idle(); rst = 1; cyc();
    idle(); #1;
    check("rst_clear", 64'(pend_vec), 64'd0);
    cyc();

    // Random traffic on a small register window to force hazards.
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_wr    = $urandom_range(0, 1);
      issue_dst   = AW'($urandom_range(0, 7));
      issue_lat   = LAT_W'($urandom_range(0, LAT_UNK));
      src_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      src_used    = 2'($urandom_range(0, 3));
      wb_valid    = ($urandom_range(0, 3) == 0);
      wb_dst      = AW'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
